post_normalizer: RTL and testbench

- Back end of the single-precision adder; the inverse of the pre-adder's unpack/align stage.
- Accepts the raw add/subtract result: sign, common biased exponent and 28-bit aligned sum mantissa.
- Normalizes it iteratively, rounds to nearest-even, and packs an IEEE-754 binary32 word plus exception flags.
- One operation in flight, with valid/ready handshakes on both sides.

---
 rtl/post_normalizer.sv | 200 ++++++++++++++++++++
 tb/tb_post_normalizer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_normalizer.sv
// Adder back end: align carry, normalize left, round to nearest-even and
// pack an IEEE-754 binary32 result with overflow/underflow/inexact flags.
module post_normalizer #(
    parameter int LSHIFT_MAX = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        SumS,
    input  logic [7:0]  SumE,
    input  logic [27:0] SumM,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        ovf,
    output logic        unf,
    output logic        inexact
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [8:0]  e_q, e_d;
    logic [27:0] m_q, m_d;
    logic        zero_q, zero_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inexact_q, inexact_d;

    logic [4:0]  lz;
    logic [8:0]  k;
    logic [27:0] m_al, m_sh;
    logic [8:0]  e_al, e_sh;
    logic        lsb, g, rs, inc;
    logic [24:0] mant_r;
    logic [23:0] mant_n;
    logic [8:0]  e_r;
    logic        tiny, ovf_r, inx_r;

    // Leading zeros counted from the hidden-bit position downwards.
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (m_q[i]) lz = 5'(26 - i);
        end
    end

    always_comb begin
        k = 9'(LSHIFT_MAX);
        if ({4'b0, lz} < k) k = {4'b0, lz};
        if (e_q - 9'd1 < k) k = e_q - 9'd1;
        m_sh = m_q << k;
        e_sh = e_q - k;
        m_al = m_q;
        e_al = e_q;
        if (m_q[27]) begin
            m_al = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
            e_al = e_q + 9'd1;
        end
    end

    always_comb begin
        lsb    = m_q[3];
        g      = m_q[2];
        rs     = m_q[1] | m_q[0];
        inc    = g & (rs | lsb);
        mant_r = {1'b0, m_q[26:3]} + {24'b0, inc};
        mant_n = mant_r[24] ? mant_r[24:1] : mant_r[23:0];
        e_r    = mant_r[24] ? e_q + 9'd1 : e_q;
        tiny   = ~m_q[26];
        inx_r  = g | rs;
        ovf_r  = mant_n[23] && (e_r >= 9'd255);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = ALIGN;
            end
            ALIGN: begin
                if (m_q == 28'd0) state_d = ROUND;
                else if (!m_al[26] && e_al > 9'd1) state_d = NORM;
                else state_d = ROUND;
            end
            NORM: begin
                if (m_sh[26] || e_sh == 9'd1) state_d = ROUND;
            end
            ROUND: state_d = DONE;
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_d       = s_q;
        e_d       = e_q;
        m_d       = m_q;
        zero_d    = zero_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d    = SumS;
                    e_d    = {1'b0, SumE};
                    m_d    = SumM;
                    zero_d = 1'b0;
                end
            end
            ALIGN: begin
                // Exact cancellation yields +0 under round-to-nearest-even.
                if (m_q == 28'd0) begin
                    zero_d = 1'b1;
                    s_d    = 1'b0;
                end else begin
                    m_d = m_al;
                    e_d = e_al;
                end
            end
            NORM: begin
                m_d = m_sh;
                e_d = e_sh;
            end
            ROUND: begin
                if (zero_q) begin
                    result_d  = 32'h0;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    inexact_d = 1'b0;
                end else if (ovf_r) begin
                    result_d  = {s_q, 8'hFF, 23'h0};
                    ovf_d     = 1'b1;
                    unf_d     = 1'b0;
                    inexact_d = 1'b1;
                end else begin
                    result_d  = {s_q, mant_n[23] ? e_r[7:0] : 8'h00,
                                 mant_n[22:0]};
                    ovf_d     = 1'b0;
                    unf_d     = tiny & inx_r;
                    inexact_d = inx_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            e_q       <= 9'd0;
            m_q       <= 28'd0;
            zero_q    <= 1'b0;
            result_q  <= 32'h0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            e_q       <= e_d;
            m_q       <= m_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        Result    = result_q;
        ovf       = ovf_q;
        unf       = unf_q;
        inexact   = inexact_q;
    end

endmodule

// File: tb/tb_post_normalizer.sv
// Bench for post_normalizer: two instances (LSHIFT_MAX 1 and 2) checked
// against directed vectors and a closed-form reference model.
module tb_post_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        SumS;
    logic [7:0]  SumE;
    logic [27:0] SumM;
    logic        out_ready;

    logic        in_ready1, out_valid1, ovf1, unf1, inexact1;
    logic [31:0] Result1;
    logic        in_ready2, out_valid2, ovf2, unf2, inexact2;
    logic [31:0] Result2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    post_normalizer #(.LSHIFT_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready1), .SumS(SumS), .SumE(SumE), .SumM(SumM),
        .out_valid(out_valid1), .out_ready(out_ready),
        .Result(Result1), .ovf(ovf1), .unf(unf1), .inexact(inexact1)
    );

    post_normalizer #(.LSHIFT_MAX(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready2), .SumS(SumS), .SumE(SumE), .SumM(SumM),
        .out_valid(out_valid2), .out_ready(out_ready),
        .Result(Result2), .ovf(ovf2), .unf(unf2), .inexact(inexact2)
    );

    // Directed vectors: flags are {ovf, unf, inexact}.
    logic [7:0]  d_e [8] = '{8'd127, 8'd127, 8'd127, 8'd127,
                             8'd127, 8'd254, 8'd1, 8'd1};
    logic [27:0] d_m [8] = '{28'h8000000, 28'h1000000, 28'h4000004,
                             28'h400000C, 28'h7FFFFFC, 28'h8000000,
                             28'h2000000, 28'h2000001};
    logic [31:0] d_r [8] = '{32'h40000000, 32'h3E800000, 32'h3F800000,
                             32'h3F800002, 32'h40000000, 32'h7F800000,
                             32'h00400000, 32'h00400000};
    logic [2:0]  d_f [8] = '{3'b000, 3'b000, 3'b001, 3'b001,
                             3'b001, 3'b101, 3'b000, 3'b011};
    int          d_l1 [8] = '{3, 5, 3, 3, 3, 3, 3, 3};
    int          d_l2 [8] = '{3, 4, 3, 3, 3, 3, 3, 3};

    task automatic model(input logic s, input logic [7:0] e,
                         input logic [27:0] m, input int L,
                         output logic [31:0] r, output logic [2:0] f,
                         output int lat);
        logic [27:0] mm;
        logic [24:0] mant;
        logic        g, rs, tiny, inx, ov;
        int          ee, lz, n, ef;
        if (m == 28'd0) begin
            r = 32'h0;
            f = 3'b000;
            lat = 3;
            return;
        end
        mm = m;
        ee = int'(e);
        if (mm[27]) begin
            mm = {1'b0, mm[27:1]} | {27'b0, m[0]};
            ee = ee + 1;
        end
        lz = 0;
        while (lz < 27 && mm[26 - lz] == 1'b0) lz++;
        n = (lz < ee - 1) ? lz : ee - 1;
        lat = 3 + (n + L - 1) / L;
        mm = mm << n;
        ee = ee - n;
        tiny = !mm[26];
        g = mm[2];
        rs = mm[1] | mm[0];
        mant = {1'b0, mm[26:3]};
        if (g && (rs || mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            ee = ee + 1;
        end
        ef = mant[23] ? ee : 0;
        inx = g | rs;
        ov = 1'b0;
        if (ef >= 255) begin
            r = {s, 8'hFF, 23'h0};
            ov = 1'b1;
            inx = 1'b1;
        end else begin
            r = {s, 8'(ef), mant[22:0]};
        end
        f = {ov, tiny & inx, inx};
    endtask

    task automatic do_op(input logic s, input logic [7:0] e,
                         input logic [27:0] m,
                         output logic [31:0] r1, output logic [2:0] f1,
                         output int l1,
                         output logic [31:0] r2, output logic [2:0] f2,
                         output int l2);
        SumS = s;
        SumE = e;
        SumM = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        l1 = -1;
        l2 = -1;
        for (int c = 1; c < 40; c++) begin
            if (out_valid1 && l1 < 0) l1 = c;
            if (out_valid2 && l2 < 0) l2 = c;
            if (l1 >= 0 && l2 >= 0) break;
            @(negedge clk);
        end
        r1 = Result1;
        f1 = {ovf1, unf1, inexact1};
        r2 = Result2;
        f2 = {ovf2, unf2, inexact2};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        SumS = 1'b0;
        SumE = 8'd0;
        SumM = 28'd0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready1, out_valid1, ovf1, unf1, inexact1} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctl1: got %b want 10000",
                     {in_ready1, out_valid1, ovf1, unf1, inexact1});
        end
        n_cmp++;
        if (Result1 !== 32'h0 || Result2 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_result: got %h/%h want 0", Result1, Result2);
        end
        n_cmp++;
        if ({in_ready2, out_valid2} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_ctl2: got %b want 10", {in_ready2, out_valid2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_hold();
        int lat;
        SumS = 1'b1;
        SumE = 8'd50;
        SumM = 28'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (out_valid1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if ({Result1, ovf1, unf1, inexact1} !== 35'h0) begin
            n_bad++;
            $display("FAIL zero_result: got %h flags %b want 0", Result1,
                     {ovf1, unf1, inexact1});
        end
        SumS = 1'b0;
        SumE = 8'd127;
        SumM = 28'h8000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid1, in_ready1, Result1} !== {2'b10, 32'h0} ||
                {out_valid2, in_ready2, Result2} !== {2'b10, 32'h0}) begin
                n_bad++;
                $display("FAIL hold_%0d: got %b %b %h want 1 0 0", i,
                         out_valid1, in_ready1, Result1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_release: got %b want 01",
                     {out_valid1, in_ready1});
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({out_valid1, in_ready1, out_valid2} !== 3'b010) begin
            n_bad++;
            $display("FAIL ignored_bundle: got %b want 010",
                     {out_valid1, in_ready1, out_valid2});
        end
    endtask

    task automatic test_directed();
        logic [31:0] r1, r2;
        logic [2:0]  f1, f2;
        int          l1, l2;
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, d_e[i], d_m[i], r1, f1, l1, r2, f2, l2);
            n_cmp++;
            if (r1 !== d_r[i] || f1 !== d_f[i]) begin
                n_bad++;
                $display("FAIL dir%0d_l1: got %h/%b want %h/%b", i, r1, f1,
                         d_r[i], d_f[i]);
            end
            n_cmp++;
            if (r2 !== d_r[i] || f2 !== d_f[i]) begin
                n_bad++;
                $display("FAIL dir%0d_l2: got %h/%b want %h/%b", i, r2, f2,
                         d_r[i], d_f[i]);
            end
            n_cmp++;
            if (l1 !== d_l1[i] || l2 !== d_l2[i]) begin
                n_bad++;
                $display("FAIL dir%0d_lat: got %0d/%0d want %0d/%0d", i, l1,
                         l2, d_l1[i], d_l2[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r1, r2;
        logic [2:0]  f1, f2;
        int          l1, l2;
        SumS = 1'b0;
        SumE = 8'd127;
        SumM = 28'h1000000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready1, out_valid1, ovf1, unf1, inexact1} !== 5'b10000 ||
            Result1 !== 32'h0 || Result2 !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b %h want 10000 0",
                     {in_ready1, out_valid1, ovf1, unf1, inexact1}, Result1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({in_ready1, out_valid1, in_ready2, out_valid2} !== 4'b1010) begin
            n_bad++;
            $display("FAIL midreset_abort: got %b want 1010",
                     {in_ready1, out_valid1, in_ready2, out_valid2});
        end
        do_op(1'b0, 8'd127, 28'h1000000, r1, f1, l1, r2, f2, l2);
        n_cmp++;
        if (r1 !== 32'h3E800000 || r2 !== 32'h3E800000 || f1 !== 3'b000) begin
            n_bad++;
            $display("FAIL midreset_next: got %h/%h want 3e800000", r1, r2);
        end
        n_cmp++;
        if (l1 !== 5 || l2 !== 4) begin
            n_bad++;
            $display("FAIL midreset_lat: got %0d/%0d want 5/4", l1, l2);
        end
    endtask

    task automatic test_random();
        logic [31:0] r1, r2, er1, er2;
        logic [2:0]  f1, f2, ef1, ef2;
        int          l1, l2, el1, el2;
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(1, 4));
                1: e = 8'($urandom_range(248, 254));
                default: e = 8'($urandom_range(1, 254));
            endcase
            m = 28'($urandom) >> $urandom_range(0, 27);
            model(s, e, m, 1, er1, ef1, el1);
            model(s, e, m, 2, er2, ef2, el2);
            do_op(s, e, m, r1, f1, l1, r2, f2, l2);
            n_cmp++;
            if (r1 !== er1 || f1 !== ef1 || l1 !== el1) begin
                n_bad++;
                $display("FAIL rnd%0d_l1 in %b/%h/%h: got %h/%b/%0d want %h/%b/%0d",
                         i, s, e, m, r1, f1, l1, er1, ef1, el1);
            end
            n_cmp++;
            if (r2 !== er2 || f2 !== ef2 || l2 !== el2) begin
                n_bad++;
                $display("FAIL rnd%0d_l2 in %b/%h/%h: got %h/%b/%0d want %h/%b/%0d",
                         i, s, e, m, r2, f2, l2, er2, ef2, el2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_hold();
        test_directed();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
